// File: rtl/spi_baud_generator_if.sv
// rtl/spi_baud_generator_if.sv - control inputs and clock/strobe outputs of the SPI baud generator
//
// Purpose: bundles the mode/config inputs and the generated clock, strobes and divisor.
// Ports (slave view, i.e. the generator):
//   spi_mode_i[1:0]        00 run, 01 wait, 10/11 stop
//   spiswai_i              halt SPI while in wait mode
//   mstr_i                 master mode
//   cpol_i, cpha_i         clock polarity / phase
//   ss_i                   active-low select from the slave-select generator
//   sppr_i[2:0], spr_i[2:0] baud prescaler / exponent
//   sclk_o                 serial clock
//   sample_strobe_o        one-PCLK pulse per sampling edge
//   shift_strobe_o         one-PCLK pulse per shifting edge
//   BaudRateDivisor_o[11:0] (sppr_i+1) << (spr_i+1)
interface spi_baud_generator_if;
    logic [1:0]  spi_mode_i;
    logic        spiswai_i;
    logic        mstr_i;
    logic        cpol_i;
    logic        cpha_i;
    logic        ss_i;
    logic [2:0]  sppr_i;
    logic [2:0]  spr_i;
    logic        sclk_o;
    logic        sample_strobe_o;
    logic        shift_strobe_o;
    logic [11:0] BaudRateDivisor_o;

    modport slave (
        input  spi_mode_i, spiswai_i, mstr_i, cpol_i, cpha_i, ss_i, sppr_i, spr_i,
        output sclk_o, sample_strobe_o, shift_strobe_o, BaudRateDivisor_o
    );

    modport master (
        output spi_mode_i, spiswai_i, mstr_i, cpol_i, cpha_i, ss_i, sppr_i, spr_i,
        input  sclk_o, sample_strobe_o, shift_strobe_o, BaudRateDivisor_o
    );
endinterface

// File: rtl/spi_baud_generator.sv
// rtl/spi_baud_generator.sv - SPI serial clock and sample/shift strobe generator
//
// Purpose: divides PCLK by BaudRateDivisor_o to produce sclk_o while the master is
// selected and allowed to run, and flags each sclk_o edge as a sample or shift edge.
// Ports:
//   PCLK      APB clock, all state updates on its rising edge
//   PRESET_n  asynchronous active-low reset
//   bus       spi_baud_generator_if.slave (config inputs, sclk/strobes/divisor outputs)
module spi_baud_generator (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    spi_baud_generator_if.slave   bus
);

    logic [11:0] divisor;
    logic [10:0] half;
    logic        enable;
    logic        leading;

    logic [10:0] count_q, count_d;
    logic        sclk_q, sclk_d;
    logic        sample_q, sample_d;
    logic        shift_q, shift_d;

    // Widen spr before the +1 so an exponent of 7 shifts by 8, not by 0.
    assign divisor = (12'(bus.sppr_i) + 12'd1) << ({1'b0, bus.spr_i} + 4'd1);
    assign half    = divisor[11:1];

    assign enable = !bus.ss_i && bus.mstr_i && !bus.spiswai_i &&
                    (bus.spi_mode_i == 2'b00 || bus.spi_mode_i == 2'b01);

    // An edge is leading when sclk is still at its idle level just before toggling.
    assign leading = (sclk_q == bus.cpol_i);

    always_comb begin
        count_d  = count_q;
        sclk_d   = sclk_q;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        if (!enable) begin
            count_d = '0;
            sclk_d  = bus.cpol_i;
        end else if (count_q == half - 11'd1) begin
            count_d  = '0;
            sclk_d   = ~sclk_q;
            // cpha=0: sample on leading, shift on trailing; cpha=1 swaps them.
            sample_d = leading ^ bus.cpha_i;
            shift_d  = ~(leading ^ bus.cpha_i);
        end else begin
            count_d = count_q + 11'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            count_q  <= '0;
            sclk_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            sclk_q   <= sclk_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
        end
    end

    assign bus.sclk_o            = sclk_q;
    assign bus.sample_strobe_o   = sample_q;
    assign bus.shift_strobe_o    = shift_q;
    assign bus.BaudRateDivisor_o = divisor;

endmodule
